// File: rtl/sar_pkg.sv
// Shared encodings for the SAR conversion sequencer and the SAR conversion timer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sar_pkg;

  // State encoding on the StateP bus; the conversion timer decodes these same values.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_SAMPLE  = 2'b01;
  localparam logic [1:0] ST_CONVERT = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

  // Default conversion width.
  localparam int SAR_NBITS_DEF = 8;

endpackage

// File: rtl/sar_approx_reg.sv
// Successive-approximation trial register: holds the DAC code plus a one-hot mask of the bit on trial.
// Latency: code updates on the edge after a load/step/write request; o_next_code is combinational.
// Backpressure: none; requests act on the next edge with priority clear > load-MSB > step > write.
module sar_approx_reg #(
  parameter int NBITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load_msb,
  input  logic             i_step,
  input  logic             i_comp,
  input  logic             i_wr,
  input  logic [NBITS-1:0] i_wr_dat,
  output logic [NBITS-1:0] o_code,
  output logic [NBITS-1:0] o_next_code,
  output logic             o_last
);

  localparam logic [NBITS-1:0] MSB = NBITS'(1) << (NBITS - 1);

  logic [NBITS-1:0] r_code;
  logic [NBITS-1:0] r_mask;
  logic [NBITS-1:0] w_step_code;

  // Resolve the bit on trial from the comparator and raise the next lower trial bit.
  always_comb begin
    w_step_code = (r_code & ~r_mask) | (i_comp ? r_mask : '0) | (r_mask >> 1);
  end

  // Trial code and mask state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (i_clear) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (i_load_msb) begin
      r_code <= MSB;
      r_mask <= MSB;
    end else if (i_step) begin
      r_code <= w_step_code;
      r_mask <= r_mask >> 1;
    end else if (i_wr) begin
      r_code <= i_wr_dat;
    end
  end

  assign o_code      = r_code;
  assign o_next_code = w_step_code;
  assign o_last      = r_mask[0];

endmodule

// File: rtl/sar_conv_sequencer.sv
// SAR ADC control sequencer: sample/convert FSM, DAC trial code, idle tracking with Inc/Dcr steps.
// Latency: Start edge to DataValid is SAMPLE_CYCLES+NBITS+1 edges; tracking steps every TRACK_DIV idle cycles.
// Backpressure: none; Start is only honoured in IDLE and is dropped (not queued) while Busy.
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int NBITS         = SAR_NBITS_DEF,
  parameter int SAMPLE_CYCLES = 4,
  parameter int TRACK_DIV     = 4
) (
  input  logic             ClockT,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             TrackEn,
  input  logic             CompIn,
  output logic [NBITS-1:0] DacCode,
  output logic [1:0]       StateP,
  output logic             Inc,
  output logic             Dcr,
  output logic [NBITS-1:0] DataOut,
  output logic             DataValid,
  output logic             Busy
);

  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TDW = (TRACK_DIV > 1) ? $clog2(TRACK_DIV) : 1;
  localparam logic [SCW-1:0]   SMP_LAST = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [TDW-1:0]   DIV_LAST = TDW'(TRACK_DIV - 1);
  localparam logic [NBITS-1:0] CODE_MAX = '1;

  logic [1:0]       r_state;
  logic [SCW-1:0]   r_smp_cnt;
  logic [TDW-1:0]   r_div_cnt;
  logic             r_have;
  logic [NBITS-1:0] r_data;
  logic             r_vld;
  logic             r_inc;
  logic             r_dcr;

  logic [NBITS-1:0] w_code;
  logic [NBITS-1:0] w_next_code;
  logic             w_last;
  logic             w_start;
  logic             w_trk_en;
  logic             w_trk_due;
  logic             w_up;
  logic             w_dn;
  logic             w_load_msb;
  logic             w_step;
  logic [NBITS-1:0] w_wr_dat;

  // Control decode: Start wins over a tracking step; tracking needs a prior result.
  always_comb begin
    w_start    = (r_state == ST_IDLE) && Start;
    w_trk_en   = (r_state == ST_IDLE) && !Start && TrackEn && r_have;
    w_trk_due  = w_trk_en && (r_div_cnt == DIV_LAST);
    w_up       = w_trk_due && CompIn && (w_code != CODE_MAX);
    w_dn       = w_trk_due && !CompIn && (w_code != '0);
    w_load_msb = (r_state == ST_SAMPLE) && (r_smp_cnt == SMP_LAST);
    w_step     = (r_state == ST_CONVERT);
    w_wr_dat   = w_up ? (w_code + NBITS'(1)) : (w_code - NBITS'(1));
  end

  sar_approx_reg #(
    .NBITS(NBITS)
  ) u_approx (
    .i_clk       (ClockT),
    .i_rst_n     (ResetN),
    .i_clear     (w_start),
    .i_load_msb  (w_load_msb),
    .i_step      (w_step),
    .i_comp      (CompIn),
    .i_wr        (w_up | w_dn),
    .i_wr_dat    (w_wr_dat),
    .o_code      (w_code),
    .o_next_code (w_next_code),
    .o_last      (w_last)
  );

  // Sample/convert state machine and sample-period counter.
  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      r_state   <= ST_IDLE;
      r_smp_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state   <= ST_SAMPLE;
            r_smp_cnt <= '0;
          end
        end
        ST_SAMPLE: begin
          r_smp_cnt <= r_smp_cnt + SCW'(1);
          if (r_smp_cnt == SMP_LAST) r_state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          if (w_last) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tracking divider: free-runs only while idle tracking is allowed, reloads on each step.
  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      r_div_cnt <= '0;
    end else if (!w_trk_en || w_trk_due) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + TDW'(1);
    end
  end

  // Result register and the one-cycle DataValid/Inc/Dcr pulses.
  always_ff @(posedge ClockT or negedge ResetN) begin
    if (!ResetN) begin
      r_data <= '0;
      r_have <= 1'b0;
      r_vld  <= 1'b0;
      r_inc  <= 1'b0;
      r_dcr  <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_inc <= 1'b0;
      r_dcr <= 1'b0;
      if (w_step && w_last) begin
        r_data <= w_next_code;
        r_have <= 1'b1;
        r_vld  <= 1'b1;
      end else if (w_up || w_dn) begin
        r_data <= w_wr_dat;
        r_vld  <= 1'b1;
        r_inc  <= w_up;
        r_dcr  <= w_dn;
      end
    end
  end

  assign DacCode   = w_code;
  assign StateP    = r_state;
  assign Inc       = r_inc;
  assign Dcr       = r_dcr;
  assign DataOut   = r_data;
  assign DataValid = r_vld;
  assign Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Bench for the SAR sequencer: comparator model plus a behavioural binary-search/tracking reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_sar_conv_sequencer;

  localparam int NB = 8;
  localparam int SC = 4;
  localparam int TD = 4;

  logic          ClockT  = 1'b0;
  logic          ResetN  = 1'b1;
  logic          Start   = 1'b0;
  logic          TrackEn = 1'b0;
  logic          CompIn;
  logic [NB-1:0] DacCode;
  logic [1:0]    StateP;
  logic          Inc;
  logic          Dcr;
  logic [NB-1:0] DataOut;
  logic          DataValid;
  logic          Busy;

  int vin    = 0;
  int total  = 0;
  int bad    = 0;
  int m_data = 0;
  int m_have = 0;
  int m_cnt  = 0;

  // Ideal comparator against the analog input level.
  assign CompIn = (vin >= int'(DacCode));

  always #5 ClockT = ~ClockT;

  sar_conv_sequencer #(
    .NBITS(NB),
    .SAMPLE_CYCLES(SC),
    .TRACK_DIV(TD)
  ) dut (
    .ClockT   (ClockT),
    .ResetN   (ResetN),
    .Start    (Start),
    .TrackEn  (TrackEn),
    .CompIn   (CompIn),
    .DacCode  (DacCode),
    .StateP   (StateP),
    .Inc      (Inc),
    .Dcr      (Dcr),
    .DataOut  (DataOut),
    .DataValid(DataValid),
    .Busy     (Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClockT);
    #1;
  endtask

  // Idle cycles: every TD enabled cycles the code walks one LSB toward vin, saturating.
  task automatic track_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int up;
      int dn;
      up = 0;
      dn = 0;
      if (TrackEn && m_have != 0) begin
        m_cnt++;
        if (m_cnt == TD) begin
          m_cnt = 0;
          if (vin >= m_data && m_data != 255) begin
            m_data++;
            up = 1;
          end else if (vin < m_data && m_data != 0) begin
            m_data--;
            dn = 1;
          end
        end
      end else begin
        m_cnt = 0;
      end
      tick();
      check("trk_inc", Inc, up);
      check("trk_dcr", Dcr, dn);
      check("trk_vld", DataValid, up | dn);
      check("trk_data", DataOut, m_data);
      check("trk_dac", DacCode, m_data);
      check("trk_both", Inc & Dcr, 0);
      check("trk_state", StateP, 0);
    end
  endtask

  // One conversion of level v; optionally re-pulse Start at cycle start_at or reset at cycle abort_at.
  task automatic convert(input int v, input int start_at, input int abort_at);
    vin   = v;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_noinc", Inc | Dcr, 0);
    for (int c = 0; c <= SC + NB; c++) begin
      int expst;
      int expdac;
      int b;
      if (c < SC) begin
        expst  = 1;
        expdac = 0;
      end else if (c < SC + NB) begin
        b      = 1 << (NB - 1 - (c - SC));
        expst  = 2;
        expdac = (v & ~((b << 1) - 1) & 255) | b;
      end else begin
        expst  = 3;
        expdac = v;
      end
      check("conv_state", StateP, expst);
      check("conv_dac", DacCode, expdac);
      check("conv_busy", Busy, 1);
      check("conv_vld", DataValid, (c == SC + NB) ? 1 : 0);
      check("conv_data", DataOut, (c == SC + NB) ? v : m_data);
      check("conv_noinc", Inc | Dcr, 0);
      if (c == abort_at) begin
        ResetN = 1'b0;
        #1;
        check("rst_state", StateP, 0);
        check("rst_dac", DacCode, 0);
        check("rst_data", DataOut, 0);
        check("rst_busy", Busy, 0);
        check("rst_vld", DataValid, 0);
        m_data = 0;
        m_have = 0;
        m_cnt  = 0;
        #2;
        ResetN = 1'b1;
        return;
      end
      if (c == start_at) Start = 1'b1;
      tick();
      Start = 1'b0;
    end
    m_data = v;
    m_have = 1;
    m_cnt  = 0;
    check("end_state", StateP, 0);
    check("end_busy", Busy, 0);
    check("end_vld", DataValid, 0);
    check("end_data", DataOut, v);
    check("end_dac", DacCode, v);
  endtask

  initial begin
    #2 ResetN = 1'b0;
    #10;
    check("rst0_state", StateP, 0);
    check("rst0_dac", DacCode, 0);
    check("rst0_data", DataOut, 0);
    check("rst0_inc", Inc, 0);
    check("rst0_dcr", Dcr, 0);
    check("rst0_vld", DataValid, 0);
    check("rst0_busy", Busy, 0);
    ResetN = 1'b1;
    tick();

    // Tracking enabled before any conversion: no steps.
    TrackEn = 1'b1;
    track_cycles(9);
    TrackEn = 1'b0;

    // Reference conversion and tracking up toward 0xA8 then dithering.
    convert(8'hA5, -1, -1);
    TrackEn = 1'b1;
    vin     = 8'hA8;
    track_cycles(28);
    TrackEn = 1'b0;

    // Full-scale and zero-scale with saturation during tracking.
    convert(8'hFF, -1, -1);
    TrackEn = 1'b1;
    track_cycles(12);
    TrackEn = 1'b0;
    convert(8'h00, -1, -1);
    TrackEn = 1'b1;
    track_cycles(12);

    // Random tracking segments with changing input level.
    for (int i = 0; i < 6; i++) begin
      TrackEn = 1'($urandom_range(0, 1));
      vin     = int'($urandom_range(0, 255));
      track_cycles(int'($urandom_range(1, 9)));
    end

    // Start lands on the same edge as a due tracking step; later Start mid-CONVERT is dropped.
    TrackEn = 1'b1;
    vin     = 8'h80;
    for (int i = 0; i < 2 * TD && m_cnt != TD - 1; i++) track_cycles(1);
    check("collide_due", m_cnt, TD - 1);
    convert(int'($urandom_range(0, 255)), SC + 3, -1);

    // Random conversions, tracking enable toggled randomly.
    for (int i = 0; i < 4; i++) begin
      TrackEn = 1'($urandom_range(0, 1));
      convert(int'($urandom_range(0, 255)), -1, -1);
      vin = int'($urandom_range(0, 255));
      track_cycles(int'($urandom_range(4, 12)));
    end

    // Reset during CONVERT on the 0xA0 trial, then tracking must stay quiet until a new result.
    TrackEn = 1'b0;
    convert(8'hA5, -1, SC + 2);
    TrackEn = 1'b1;
    vin     = 8'h40;
    track_cycles(12);
    convert(8'h3C, -1, -1);
    vin = 8'h40;
    track_cycles(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
